// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RV64 load/store unit: request classes, the UART
// region index and a constant-width helper.
package riscv_lsu_pkg;

    localparam logic [4:0] NORMAL_READ  = 5'b00001;
    localparam logic [4:0] NORMAL_WRITE = 5'b00010;
    localparam logic [4:0] LR           = 5'b00100;
    localparam logic [4:0] SC           = 5'b01000;
    localparam logic [4:0] AMO          = 5'b10000;

    localparam int UART_REGION = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/riscv_lsu_tx_fifo.sv
// Synchronous FIFO for UART TX bytes; a push while full is accepted only
// when a pop happens in the same cycle.
module riscv_lsu_tx_fifo
    import riscv_lsu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == COUNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/riscv_lsu_mmio.sv
// Memory-stage LSU: request classification, MMIO region decode, LR/SC
// reservation and UART TX buffering. Optional reservation timeout: RISCV_LSU_RSV_TIMEOUT_EN.
module riscv_lsu_mmio
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int N_REGIONS = 4,
    parameter logic [N_REGIONS*XLEN-1:0] REGION_BASE = {N_REGIONS{{XLEN{1'b0}}}},
    parameter logic [N_REGIONS*XLEN-1:0] REGION_MASK = {N_REGIONS{{{(XLEN-3){1'b1}}, 3'b000}}},
    parameter int RSV_GRANULE_LOG2 = 3,
    parameter int RSV_TIMEOUT = 128,
    parameter int TX_DEPTH = 4
) (
    input  logic                 i_riscv_lsu_clk,
    input  logic                 i_riscv_lsu_rst,
    input  logic                 i_riscv_lsu_globstall,
    input  logic [XLEN-1:0]      i_riscv_lsu_rs1,
    input  logic [XLEN-1:0]      i_riscv_lsu_alu_result,
    input  logic [7:0]           i_riscv_lsu_store_data,
    input  logic                 i_riscv_lsu_rden,
    input  logic                 i_riscv_lsu_wren,
    input  logic                 i_riscv_lsu_amo,
    input  logic [1:0]           i_riscv_lsu_lr,
    input  logic [1:0]           i_riscv_lsu_sc,
    input  logic                 i_riscv_lsu_goto_trap,
    input  logic [1:0]           i_riscv_lsu_return_trap,
    output logic                 o_riscv_lsu_dcache_rden,
    output logic                 o_riscv_lsu_dcache_wren,
    output logic [XLEN-1:0]      o_riscv_lsu_phy_address,
    output logic [XLEN-1:0]      o_riscv_lsu_sc_rdvalue,
    output logic [N_REGIONS-1:0] o_riscv_lsu_region_rden,
    output logic [N_REGIONS-1:0] o_riscv_lsu_region_wren,
    output logic                 o_riscv_lsu_mmio_stall,
    output logic                 o_riscv_lsu_uart_tx_valid,
    output logic [7:0]           o_riscv_lsu_uart_tx_data,
    input  logic                 i_riscv_lsu_uart_tx_ready
);

    localparam int GRAN_W = XLEN - RSV_GRANULE_LOG2;
    localparam int CNT_W  = clog2(TX_DEPTH + 1);

    if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 || RSV_TIMEOUT < 1) begin : g_bad_cfg
        $error("riscv_lsu_mmio: TX_DEPTH must be a power of two >= 2 and RSV_TIMEOUT >= 1");
    end

    logic [4:0]            req_class;
    logic                  is_read, is_store, is_lr, is_sc, is_amo, kill;
    logic [XLEN-1:0]       addr;
    logic [GRAN_W-1:0]     addr_gran;
    logic [N_REGIONS-1:0]  hit_vec, win_onehot;
    logic                  any_hit, gran_match, sc_ok;
    logic                  uart_store, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  rsv_valid_q, rsv_valid_d, rsv_dword_q, rsv_dword_d;
    logic [GRAN_W-1:0]     rsv_granule_q, rsv_granule_d;
`ifdef RISCV_LSU_RSV_TIMEOUT_EN
    localparam int TMO_W = clog2(RSV_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(RSV_TIMEOUT);
    logic [TMO_W-1:0]      rsv_cnt_q, rsv_cnt_d;
`endif

    // One class per request; atomics take precedence if a decoder ever overlaps them.
    always_comb begin
        req_class = '0;
        if (i_riscv_lsu_lr[1])        req_class = LR;
        else if (i_riscv_lsu_sc[1])   req_class = SC;
        else if (i_riscv_lsu_amo)     req_class = AMO;
        else if (i_riscv_lsu_wren)    req_class = NORMAL_WRITE;
        else if (i_riscv_lsu_rden)    req_class = NORMAL_READ;
    end

    assign is_read  = (req_class == NORMAL_READ);
    assign is_store = (req_class == NORMAL_WRITE);
    assign is_lr    = (req_class == LR);
    assign is_sc    = (req_class == SC);
    assign is_amo   = (req_class == AMO);
    assign kill     = i_riscv_lsu_goto_trap | (|i_riscv_lsu_return_trap);

    assign addr      = (is_lr | is_sc | is_amo) ? i_riscv_lsu_rs1 : i_riscv_lsu_alu_result;
    assign addr_gran = addr[XLEN-1:RSV_GRANULE_LOG2];

    always_comb begin
        hit_vec = '0;
        for (int k = 0; k < N_REGIONS; k++) begin
            hit_vec[k] = ((addr & REGION_MASK[k*XLEN +: XLEN]) ==
                          (REGION_BASE[k*XLEN +: XLEN] & REGION_MASK[k*XLEN +: XLEN]));
        end
    end

    // Isolate the lowest set bit so overlapping regions resolve to the lowest index.
    assign win_onehot = hit_vec & (~hit_vec + 1'b1);
    assign any_hit    = |hit_vec;

    assign gran_match = (rsv_granule_q == addr_gran);
    assign sc_ok      = is_sc & rsv_valid_q & gran_match & (rsv_dword_q == i_riscv_lsu_sc[0])
                        & ~kill & ~any_hit;

    assign o_riscv_lsu_dcache_rden = ~kill & ~any_hit & (is_read | is_lr | is_amo);
    assign o_riscv_lsu_dcache_wren = ~kill & ~any_hit & (is_store | sc_ok);
    assign o_riscv_lsu_phy_address = any_hit ? '0 : addr;
    assign o_riscv_lsu_sc_rdvalue  = {{(XLEN-1){1'b0}}, is_sc & ~sc_ok};
    assign o_riscv_lsu_region_rden = (~kill & is_read) ? win_onehot : '0;
    assign o_riscv_lsu_region_wren = (~kill & is_store & ~win_onehot[UART_REGION]) ? win_onehot : '0;

    // A full FIFO still takes the store if the UART drains its head this cycle.
    assign uart_store             = is_store & win_onehot[UART_REGION] & ~kill;
    assign fifo_pop               = ~fifo_empty & i_riscv_lsu_uart_tx_ready;
    assign fifo_push              = uart_store & (~fifo_full | i_riscv_lsu_uart_tx_ready);
    assign o_riscv_lsu_mmio_stall = uart_store & fifo_full & ~i_riscv_lsu_uart_tx_ready;
    assign o_riscv_lsu_uart_tx_valid = (fifo_count != '0);

    riscv_lsu_tx_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i   (i_riscv_lsu_clk),
        .rst_i   (i_riscv_lsu_rst),
        .push_i  (fifo_push),
        .data_i  (i_riscv_lsu_store_data),
        .pop_i   (fifo_pop),
        .data_o  (o_riscv_lsu_uart_tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        rsv_valid_d   = rsv_valid_q;
        rsv_granule_d = rsv_granule_q;
        rsv_dword_d   = rsv_dword_q;
`ifdef RISCV_LSU_RSV_TIMEOUT_EN
        rsv_cnt_d     = rsv_cnt_q;
`endif
        if (!i_riscv_lsu_globstall) begin
            if (kill) begin
                rsv_valid_d = 1'b0;
            end else if (is_lr) begin
                rsv_valid_d   = 1'b1;
                rsv_granule_d = addr_gran;
                rsv_dword_d   = i_riscv_lsu_lr[0];
`ifdef RISCV_LSU_RSV_TIMEOUT_EN
                rsv_cnt_d     = '0;
`endif
            end else if (is_sc) begin
                rsv_valid_d = 1'b0;
            end else if ((is_store | is_amo) && gran_match) begin
                rsv_valid_d = 1'b0;
            end
`ifdef RISCV_LSU_RSV_TIMEOUT_EN
            else if (rsv_valid_q) begin
                rsv_cnt_d = rsv_cnt_q + 1'b1;
                if (rsv_cnt_d == TMO_LIMIT) rsv_valid_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
        if (i_riscv_lsu_rst) begin
            rsv_valid_q   <= 1'b0;
            rsv_granule_q <= '0;
            rsv_dword_q   <= 1'b0;
`ifdef RISCV_LSU_RSV_TIMEOUT_EN
            rsv_cnt_q     <= '0;
`endif
        end else begin
            rsv_valid_q   <= rsv_valid_d;
            rsv_granule_q <= rsv_granule_d;
            rsv_dword_q   <= rsv_dword_d;
`ifdef RISCV_LSU_RSV_TIMEOUT_EN
            rsv_cnt_q     <= rsv_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_riscv_lsu_mmio.sv
// Bench for riscv_lsu_mmio: directed requests, a behavioural reservation/FIFO
// model checked every cycle, and literal expectations from the test plan.
`timescale 1ns/1ps
module tb_riscv_lsu_mmio;
  localparam int XLEN = 64;
  localparam int NR   = 4;
  localparam int TXD  = 4;
  localparam int TMO  = 8;
  localparam logic [63:0] BASE_A [4] = '{64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h2000_0000};
  localparam logic [63:0] MASK_A [4] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_F000,
                                          64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_F000};
  localparam logic [NR*XLEN-1:0] BASE = {BASE_A[3], BASE_A[2], BASE_A[1], BASE_A[0]};
  localparam logic [NR*XLEN-1:0] MASK = {MASK_A[3], MASK_A[2], MASK_A[1], MASK_A[0]};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            gstall = 1'b0;
  logic [XLEN-1:0] rs1 = '0, alu = '0;
  logic [7:0]      sdata = '0;
  logic            rden = 1'b0, wren = 1'b0, amo = 1'b0;
  logic [1:0]      lr = '0, sc = '0;
  logic            gtrap = 1'b0;
  logic [1:0]      rtrap = '0;
  logic            tx_ready = 1'b0;

  logic            dc_rden, dc_wren, mmio_stall, tx_valid;
  logic [XLEN-1:0] phy, sc_val;
  logic [NR-1:0]   reg_rden, reg_wren;
  logic [7:0]      tx_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic            m_rsv_valid = 1'b0;
  logic [XLEN-1:0] m_gran = '0;
  logic            m_dword = 1'b0;
  int              m_idle = 0;
  logic [7:0]      exp_q[$];
  logic [7:0]      drained_q[$];

  riscv_lsu_mmio #(
    .XLEN(XLEN), .N_REGIONS(NR), .REGION_BASE(BASE), .REGION_MASK(MASK),
    .RSV_GRANULE_LOG2(3), .RSV_TIMEOUT(TMO), .TX_DEPTH(TXD)
  ) dut (
    .i_riscv_lsu_clk(clk), .i_riscv_lsu_rst(rst), .i_riscv_lsu_globstall(gstall),
    .i_riscv_lsu_rs1(rs1), .i_riscv_lsu_alu_result(alu), .i_riscv_lsu_store_data(sdata),
    .i_riscv_lsu_rden(rden), .i_riscv_lsu_wren(wren), .i_riscv_lsu_amo(amo),
    .i_riscv_lsu_lr(lr), .i_riscv_lsu_sc(sc),
    .i_riscv_lsu_goto_trap(gtrap), .i_riscv_lsu_return_trap(rtrap),
    .o_riscv_lsu_dcache_rden(dc_rden), .o_riscv_lsu_dcache_wren(dc_wren),
    .o_riscv_lsu_phy_address(phy), .o_riscv_lsu_sc_rdvalue(sc_val),
    .o_riscv_lsu_region_rden(reg_rden), .o_riscv_lsu_region_wren(reg_wren),
    .o_riscv_lsu_mmio_stall(mmio_stall), .o_riscv_lsu_uart_tx_valid(tx_valid),
    .o_riscv_lsu_uart_tx_data(tx_data), .i_riscv_lsu_uart_tx_ready(tx_ready)
  );

  // Clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end (checks=%0d)", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model helpers, phrased in terms of the request rules
  function automatic int region_of(input logic [XLEN-1:0] a);
    for (int k = 0; k < NR; k++)
      if ((a & MASK_A[k]) == (BASE_A[k] & MASK_A[k])) return k;
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] eff_addr();
    return (lr[1] || sc[1] || amo) ? rs1 : alu;
  endfunction

  function automatic logic killed();
    return gtrap || (rtrap != 2'b00);
  endfunction

  function automatic logic model_sc_ok();
    logic [XLEN-1:0] a;
    a = eff_addr();
    return sc[1] && m_rsv_valid && ((a >> 3) == m_gran) && (m_dword == sc[0])
           && !killed() && (region_of(a) < 0);
  endfunction

  // Model update on each edge
  always @(posedge clk or posedge rst) begin
    logic [XLEN-1:0] a;
    int r;
    logic do_pop, do_push;
    if (rst) begin
      m_rsv_valid = 1'b0; m_gran = '0; m_dword = 1'b0; m_idle = 0;
      exp_q.delete();
    end else begin
      a = eff_addr();
      r = region_of(a);
      do_pop  = (exp_q.size() != 0) && tx_ready;
      do_push = !killed() && wren && (r == 0) && ((exp_q.size() < TXD) || tx_ready);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(sdata);
      if (!gstall) begin
        if (killed()) m_rsv_valid = 1'b0;
        else if (lr[1]) begin
          m_rsv_valid = 1'b1; m_gran = a >> 3; m_dword = lr[0]; m_idle = 0;
        end
        else if (sc[1]) m_rsv_valid = 1'b0;
        else if ((wren || amo) && ((a >> 3) == m_gran)) m_rsv_valid = 1'b0;
        else if (m_rsv_valid) begin
          m_idle++;
`ifdef RISCV_LSU_RSV_TIMEOUT_EN
          if (m_idle >= TMO) m_rsv_valid = 1'b0;
`endif
        end
      end
    end
  end

  // Scoreboard compare every cycle, away from the active edge
  always @(negedge clk) begin
    logic [XLEN-1:0] a;
    int r;
    logic k, ok;
    logic [NR-1:0] e_rr, e_rw;
    if (!rst) begin
      a  = eff_addr();
      r  = region_of(a);
      k  = killed();
      ok = model_sc_ok();
      e_rr = (!k && rden && r >= 0) ? NR'(1 << r) : '0;
      e_rw = (!k && wren && r > 0) ? NR'(1 << r) : '0;
      check("m_dcache_rden", dc_rden, !k && r < 0 && (rden || lr[1] || amo));
      check("m_dcache_wren", dc_wren, !k && r < 0 && (wren || ok));
      check("m_phy_address", phy, (r >= 0) ? '0 : a);
      check("m_sc_rdvalue", sc_val, sc[1] ? {63'd0, !ok} : '0);
      check("m_region_rden", reg_rden, e_rr);
      check("m_region_wren", reg_wren, e_rw);
      check("m_mmio_stall", mmio_stall,
            !k && wren && r == 0 && exp_q.size() == TXD && !tx_ready);
      check("m_tx_valid", tx_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("m_tx_data", tx_data, exp_q[0]);
      if (tx_valid && tx_ready) drained_q.push_back(tx_data);
    end
  end

  // Driver tasks
  task automatic begin_cycle();
    @(posedge clk); #1;
    rden = 0; wren = 0; amo = 0; lr = '0; sc = '0; gtrap = 0; rtrap = '0;
    gstall = 0; rs1 = '0; alu = '0; sdata = '0;
  endtask

  task automatic do_load(input logic [XLEN-1:0] a);
    begin_cycle(); rden = 1; alu = a; @(negedge clk);
  endtask
  task automatic do_store(input logic [XLEN-1:0] a, input logic [7:0] d);
    begin_cycle(); wren = 1; alu = a; sdata = d; @(negedge clk);
  endtask
  task automatic do_lr(input logic [XLEN-1:0] a, input logic dw);
    begin_cycle(); lr = {1'b1, dw}; rs1 = a; @(negedge clk);
  endtask
  task automatic do_sc(input logic [XLEN-1:0] a, input logic dw);
    begin_cycle(); sc = {1'b1, dw}; rs1 = a; @(negedge clk);
  endtask
  task automatic do_amo(input logic [XLEN-1:0] a);
    begin_cycle(); amo = 1; rs1 = a; @(negedge clk);
  endtask
  task automatic do_idle(input int n, input logic stall);
    for (int i = 0; i < n; i++) begin
      begin_cycle(); gstall = stall; @(negedge clk);
    end
  endtask

  localparam logic [XLEN-1:0] UART = 64'h1000_0000;

  initial begin
    logic [7:0] want [5];
    int budget;
    want = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dcache_rden", dc_rden, 0);
    check("rst_dcache_wren", dc_wren, 0);
    check("rst_phy", phy, 0);
    check("rst_sc", sc_val, 0);
    check("rst_region_rw", {reg_rden, reg_wren}, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_stall", mmio_stall, 0);
    rst = 0;

    // Plain load, region loads/stores, overlap priority
    do_load(64'h8000_0000);
    check("load_dcache_rden", dc_rden, 1);
    check("load_phy", phy, 64'h8000_0000);
    check("load_region_rden", reg_rden, 4'b0000);
    do_load(64'h2000_0010);
    check("overlap_region_rden", reg_rden, 4'b0010);
    check("overlap_phy", phy, 0);
    do_store(64'h3000_0008, 8'h00);
    check("region2_wren", reg_wren, 4'b0100);
    check("region2_dcache_wren", dc_wren, 0);

    // LR/SC success then second SC fails
    do_lr(64'h1000, 1);
    check("lr_dcache_rden", dc_rden, 1);
    do_sc(64'h1004, 1);
    check("sc1_value", sc_val, 0);
    check("sc1_wren", dc_wren, 1);
    do_sc(64'h1004, 1);
    check("sc2_value", sc_val, 1);
    check("sc2_wren", dc_wren, 0);

    // Store snoop and width mismatch
    do_lr(64'h1000, 1);
    do_store(64'h1000, 8'h00);
    do_sc(64'h1000, 1);
    check("snoop_sc_value", sc_val, 1);
    do_lr(64'h1000, 0);
    do_sc(64'h1000, 1);
    check("width_sc_value", sc_val, 1);
    do_lr(64'h1000, 1);
    do_store(64'h1008, 8'h00);
    do_sc(64'h1000, 1);
    check("other_granule_sc_value", sc_val, 0);
    do_lr(64'h1000, 1);
    do_amo(64'h1000);
    check("amo_dcache_rden", dc_rden, 1);
    do_sc(64'h1000, 1);
    check("amo_snoop_sc_value", sc_val, 1);

    // Atomics hitting a region
    do_lr(64'h2000_0000, 1);
    check("lr_region_rden", {reg_rden, 3'b000, dc_rden}, 0);
    do_sc(64'h2000_0000, 1);
    check("sc_region_value", sc_val, 1);
    check("sc_region_wren", {reg_wren, 3'b000, dc_wren}, 0);

    // UART FIFO fill, stall, simultaneous push/pop, drain
    tx_ready = 0;
    for (int i = 0; i < 4; i++) begin
      do_store(UART, 8'h41 + 8'(i));
      check("uart_no_stall", mmio_stall, 0);
      check("uart_region_wren", reg_wren, 0);
      if (i == 1) check("uart_head", {tx_valid, tx_data}, {1'b1, 8'h41});
    end
    do_store(UART, 8'h45);
    check("uart_fifth_stall", mmio_stall, 1);
    do_store(UART, 8'h45);
    check("uart_fifth_stall_hold", mmio_stall, 1);
    begin_cycle(); tx_ready = 1; wren = 1; alu = UART; sdata = 8'h45; @(negedge clk);
    check("uart_full_pushpop_stall", mmio_stall, 0);
    budget = 0;
    while (drained_q.size() < 5 && budget < 20) begin
      do_idle(1, 0);
      budget++;
    end
    check("uart_drain_count", drained_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < drained_q.size()) check("uart_drain_order", drained_q[i], want[i]);
    check("uart_empty_after", tx_valid, 0);

    // Trap suppression
    begin_cycle(); wren = 1; alu = 64'h8000_0100; gtrap = 1; @(negedge clk);
    check("trap_store_wren", dc_wren, 0);
    begin_cycle(); wren = 1; alu = UART; sdata = 8'h77; gtrap = 1; @(negedge clk);
    check("trap_uart_stall", mmio_stall, 0);
    do_idle(1, 0);
    check("trap_uart_no_push", tx_valid, 0);
    begin_cycle(); rden = 1; alu = 64'h8000_0000; rtrap = 2'b01; @(negedge clk);
    check("rtrap_load_rden", dc_rden, 0);
    do_lr(64'h1000, 1);
    begin_cycle(); wren = 1; alu = 64'h8000_0000; rtrap = 2'b10; @(negedge clk);
    do_sc(64'h1000, 1);
    check("trap_clears_rsv", sc_val, 1);
    do_lr(64'h1000, 1);
    begin_cycle(); sc = 2'b11; rs1 = 64'h1000; gtrap = 1; @(negedge clk);
    check("trap_sc_value", sc_val, 1);
    check("trap_sc_wren", dc_wren, 0);

    // Reservation timeout boundary
    do_lr(64'h1000, 1);
    do_idle(7, 0);
    do_sc(64'h1000, 1);
    check("tmo_7_idle", sc_val, 0);
    do_lr(64'h1000, 1);
    do_idle(8, 0);
    do_sc(64'h1000, 1);
`ifdef RISCV_LSU_RSV_TIMEOUT_EN
    check("tmo_8_idle", sc_val, 1);
`else
    check("tmo_8_idle", sc_val, 0);
`endif
    do_lr(64'h1000, 1);
    do_idle(3, 1);
    do_idle(7, 0);
    do_sc(64'h1000, 1);
    check("tmo_stall_not_counted", sc_val, 0);

    // Reset mid-operation discards FIFO contents
    tx_ready = 0;
    do_store(UART, 8'h55);
    do_idle(1, 0);
    check("pre_reset_tx_valid", tx_valid, 1);
    #2 rst = 1;
    #2 check("async_reset_flush", tx_valid, 0);
    @(negedge clk);
    rst = 0;
    do_idle(2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_lsu_mmio.md
# riscv_lsu_mmio

Parametrised second-generation load/store unit for the RV64 core's memory stage. It classifies each request (load, store, LR, SC, AMO) and suppresses it on trap entry or return. It decodes the address against N base/mask regions, routing each request to the data cache or to exactly one memory-mapped region. It also holds a granule-based LR/SC reservation with store snooping and an optional timeout, and buffers UART TX bytes in a small FIFO with a valid/ready drain.

## Interface
- XLEN, 64, address/data width
- N_REGIONS, 4, number of MMIO regions (≥1); region 0 is always the UART TX register
- REGION_BASE, {N_REGIONS{XLEN'h0}} packed, per-region base, region k in bits [k*XLEN +: XLEN]
- REGION_MASK, {N_REGIONS{XLEN'hFFFF_FFFF_FFFF_FFF8}} packed, per-region compare mask
- RSV_GRANULE_LOG2, 3, reservation granule size is 2^RSV_GRANULE_LOG2 bytes
- RSV_TIMEOUT, 128, unstalled cycles after LR before the reservation expires
- TX_DEPTH, 4, UART FIFO depth (power of two, ≥2)
- i_riscv_lsu_clk  in  1  clock; single clock domain
- i_riscv_lsu_rst  in  1  reset; asynchronous, active-high
- i_riscv_lsu_globstall  in  1  global pipeline stall
- i_riscv_lsu_rs1  in  XLEN  LR/SC/AMO address
- i_riscv_lsu_alu_result  in  XLEN  load/store effective address
- i_riscv_lsu_store_data  in  8  low byte of store data (UART payload)
- i_riscv_lsu_rden / i_riscv_lsu_wren / i_riscv_lsu_amo  in  1 each  request class
- i_riscv_lsu_lr / i_riscv_lsu_sc  in  2 each  [1] valid, [0] doubleword
- i_riscv_lsu_goto_trap  in  1  trap entry this cycle
- i_riscv_lsu_return_trap  in  2  trap return this cycle
- o_riscv_lsu_dcache_rden / o_riscv_lsu_dcache_wren  out  1 each  cache strobes
- o_riscv_lsu_phy_address  out  XLEN  cache address
- o_riscv_lsu_sc_rdvalue  out  XLEN  SC result (0 success, 1 fail)
- o_riscv_lsu_region_rden / o_riscv_lsu_region_wren  out  N_REGIONS each  one-hot MMIO strobes (bit 0 never set on write; UART writes go to the FIFO)
- o_riscv_lsu_mmio_stall  out  1  request global stall (UART FIFO full)
- o_riscv_lsu_uart_tx_valid  out  1  FIFO non-empty
- o_riscv_lsu_uart_tx_data  out  8  FIFO head
- i_riscv_lsu_uart_tx_ready  in  1  UART accepts head

## Operation
- kill = goto_trap | (|return_trap). Every strobe and FIFO push is gated by !kill.
- Effective address: alu_result for rden and wren; rs1 for LR, SC and AMO.
- Region hit: hit[k] = (addr & MASK[k]) == (BASE[k] & MASK[k]). On multiple hits, the lowest k wins. Any hit blanks the cache strobes and forces phy_address to 0.
- LR, SC and AMO that hit a region: strobes are suppressed and the SC fails.
- No hit: the cache path behaves per class. Load, LR and AMO raise rden. Store raises wren. SC raises wren only on success.
- Reservation state: rsv_valid, rsv_granule = addr[XLEN-1:RSV_GRANULE_LOG2], rsv_dword.
- SC succeeds when all of these hold: rsv_valid, granule match, rsv_dword == sc[0], and !kill.
- Reservation update on a clock edge with !globstall, in priority order:
  - kill: clear
  - LR: set
  - SC: clear, whether it succeeds or fails
  - store or AMO to the reserved granule: clear
  - timeout: clear
- UART push: a store hitting region 0 pushes store_data when the FIFO is not full. Pop occurs on tx_valid & tx_ready.
- When the FIFO is full, a simultaneous push and pop is allowed. Count is unchanged and no stall is raised.
- mmio_stall = UART store & !kill & full & !tx_ready (combinational). While it is asserted, no push occurs.

## Timing
- All request outputs are combinational in the same cycle.
- Reservation, FIFO and timeout state update on the rising edge. FIFO and UART drain advance even during globstall.
- Reset values:
  - all outputs 0; tx_valid 0
  - rsv_valid 0, rsv_granule 0, timeout counter 0
  - FIFO pointers and count 0
- Reset asserted mid-operation discards FIFO contents immediately.
- Pointers wrap modulo TX_DEPTH. Count spans 0..TX_DEPTH.
- First-word latency from push to tx_valid is 1 cycle.

## Configuration
- RISCV_LSU_RSV_TIMEOUT_EN defined:
  - A counter of width clog2(RSV_TIMEOUT+1) loads 0 on LR and increments on unstalled cycles while rsv_valid.
  - The reservation clears when the counter reaches RSV_TIMEOUT.
- Not defined: the counter is absent and the reservation persists until trap, SC or snooped store.

## Structure
- riscv_lsu_pkg holds:
  - request-class one-hot localparams (NORMAL_READ, NORMAL_WRITE, LR, SC, AMO)
  - the region index of the UART, UART_REGION = 0
  - the clog2 helper
- Sub-module riscv_lsu_tx_fifo: parametrised synchronous FIFO (width 8, depth TX_DEPTH) with full, empty and count.

## Test plan
- Reset, then a load at 0x8000_0000 with no hit → dcache_rden=1, phy_address=0x8000_0000; all region strobes 0.
- LR.D at 0x1000, then SC.D at 0x1004 (same 8-byte granule) → sc_rdvalue=0, dcache_wren=1. A second SC → sc_rdvalue=1, wren=0.
- LR.D at 0x1000, then SD to 0x1000, then SC.D at 0x1000 → SC fails (1). An LR.W followed by SC.D also fails.
- Hold tx_ready=0 and perform five stores of 0x41..0x45 to UART_BASE with TX_DEPTH=4:
  - mmio_stall=1 on the fifth store.
  - After tx_ready=1, the bytes drain 0x41..0x45 in order.
- goto_trap=1 during a store to a cache address or to UART → all strobes 0, no push, reservation cleared.
- With RISCV_LSU_RSV_TIMEOUT_EN and RSV_TIMEOUT=8: LR, then 8 idle cycles, then SC → fails. With 7 idle cycles → succeeds.
